// File: rtl/move_executor_if.sv
// Request/response and board-state bundle between a move requester and
// move_executor. The requester drives the request fields; the executor
// returns the handshake, result flags and both sides' board vectors.
interface move_executor_if;
    logic        move_valid;
    logic        pl;
    logic [3:0]  piece_in;
    logic [5:0]  move_in;
    logic        ready;
    logic        done;
    logic        error;
    logic        captured;
    logic [3:0]  captured_piece;
    logic [95:0] location_vectors_w;
    logic [95:0] location_vectors_b;
    logic [15:0] alive_vectors_w;
    logic [15:0] alive_vectors_b;

    modport master (
        output move_valid, pl, piece_in, move_in,
        input  ready, done, error, captured, captured_piece,
        input  location_vectors_w, location_vectors_b,
        input  alive_vectors_w, alive_vectors_b
    );

    modport slave (
        input  move_valid, pl, piece_in, move_in,
        output ready, done, error, captured, captured_piece,
        output location_vectors_w, location_vectors_b,
        output alive_vectors_w, alive_vectors_b
    );
endinterface

// File: rtl/move_executor.sv
// Chess move executor: holds both sides' piece squares and alive masks,
// accepts one move at a time, scans all 16 indices one per cycle for
// own-piece blocking and opponent capture, then commits the board update.
// Only occupancy and liveness are checked; piece movement rules are not.
module move_executor #(
    parameter logic WHITE = 1'b1,
    parameter logic BLACK = 1'b0
) (
    input  logic           clk,
    input  logic           RST,
    move_executor_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SCAN,
        S_COMMIT,
        S_DONE
    } state_t;

    // Start-of-game squares. Back-rank indices follow the K1,Q1,B2,B1,N2,N1,
    // R2,R1 order; pawn index 8 is P8 and index 15 is P1, so pawns run
    // downward in file. Black sits 56 (back rank) / 40 (pawns) squares up.
    function automatic logic [95:0] f_init_loc(input logic is_black);
        logic [95:0] v;
        logic [5:0]  sq;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       sq = 6'd4;
                1:       sq = 6'd3;
                2:       sq = 6'd5;
                3:       sq = 6'd2;
                4:       sq = 6'd6;
                5:       sq = 6'd1;
                6:       sq = 6'd7;
                7:       sq = 6'd0;
                default: sq = 6'(23 - i);
            endcase
            if (is_black) sq = sq + ((i < 8) ? 6'd56 : 6'd40);
            v[6*i +: 6] = sq;
        end
        return v;
    endfunction

    localparam logic [95:0] LOC_W0 = f_init_loc(1'b0);
    localparam logic [95:0] LOC_B0 = f_init_loc(1'b1);

    state_t      r_state;
    state_t      w_nxt;
    logic        w_set_err;

    logic        r_pl;
    logic [3:0]  r_piece;
    logic [5:0]  r_move;
    logic [3:0]  r_k;
    logic        r_cap;
    logic [3:0]  r_cap_idx;

    logic [95:0] r_loc_w;
    logic [95:0] r_loc_b;
    logic [15:0] r_alive_w;
    logic [15:0] r_alive_b;

    logic        r_ready;
    logic        r_done;
    logic        r_error;
    logic        r_captured;
    logic [3:0]  r_captured_piece;

    logic        w_mv_w;
    logic [95:0] w_mv_loc;
    logic [95:0] w_op_loc;
    logic [15:0] w_mv_alive;
    logic [15:0] w_op_alive;
    logic [6:0]  w_k_off;
    logic [6:0]  w_p_off;
    logic        w_mv_hit;
    logic        w_op_hit;

    // Mover/opponent views of the board, selected by the latched side.
    assign w_mv_w     = (r_pl == WHITE);
    assign w_mv_loc   = w_mv_w ? r_loc_w   : r_loc_b;
    assign w_op_loc   = w_mv_w ? r_loc_b   : r_loc_w;
    assign w_mv_alive = w_mv_w ? r_alive_w : r_alive_b;
    assign w_op_alive = w_mv_w ? r_alive_b : r_alive_w;

    assign w_k_off  = {3'd0, r_k} * 7'd6;
    assign w_p_off  = {3'd0, r_piece} * 7'd6;
    // Dead pieces keep their last square, so liveness gates every match.
    assign w_mv_hit = w_mv_alive[r_k] && (w_mv_loc[w_k_off +: 6] == r_move);
    assign w_op_hit = w_op_alive[r_k] && (w_op_loc[w_k_off +: 6] == r_move);

    // State register.
    always_ff @(posedge clk) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    // Next-state decode; w_set_err flags a transition into DONE as a reject.
    always_comb begin
        w_nxt     = r_state;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.move_valid) w_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!w_mv_alive[r_piece]) begin
                    w_nxt     = S_DONE;
                    w_set_err = 1'b1;
                end else begin
                    w_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_mv_hit) begin
                    w_nxt     = S_DONE;
                    w_set_err = 1'b1;
                end else if (r_k == 4'd15) begin
                    w_nxt = S_COMMIT;
                end
            end
            S_COMMIT: w_nxt = S_DONE;
            S_DONE:   w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // Request latch, scan index and capture tracking.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_pl      <= 1'b0;
            r_piece   <= 4'd0;
            r_move    <= 6'd0;
            r_k       <= 4'd0;
            r_cap     <= 1'b0;
            r_cap_idx <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.move_valid) begin
                        r_pl    <= bus.pl;
                        r_piece <= bus.piece_in;
                        r_move  <= bus.move_in;
                    end
                end
                S_CHECK: begin
                    r_k       <= 4'd0;
                    r_cap     <= 1'b0;
                    r_cap_idx <= 4'd0;
                end
                S_SCAN: begin
                    if (w_op_hit) begin
                        r_cap     <= 1'b1;
                        r_cap_idx <= r_k;
                    end
                    if (r_k != 4'd15) r_k <= r_k + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Board state: written only in COMMIT, restored to the opening on reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_loc_w   <= LOC_W0;
            r_loc_b   <= LOC_B0;
            r_alive_w <= 16'hFFFF;
            r_alive_b <= 16'hFFFF;
        end else if (r_state == S_COMMIT) begin
            if (w_mv_w) begin
                r_loc_w[w_p_off +: 6] <= r_move;
                if (r_cap) r_alive_b[r_cap_idx] <= 1'b0;
            end else if (r_pl == BLACK) begin
                r_loc_b[w_p_off +: 6] <= r_move;
                if (r_cap) r_alive_w[r_cap_idx] <= 1'b0;
            end
        end
    end

    // Registered handshake/result outputs, loaded from the next state so
    // they line up with DONE/IDLE; a reject suppresses any pending capture.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_ready          <= 1'b1;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_captured       <= 1'b0;
            r_captured_piece <= 4'd0;
        end else begin
            r_ready          <= (w_nxt == S_IDLE);
            r_done           <= (w_nxt == S_DONE);
            r_error          <= (w_nxt == S_DONE) && w_set_err;
            r_captured       <= (w_nxt == S_DONE) && !w_set_err && r_cap;
            r_captured_piece <= ((w_nxt == S_DONE) && !w_set_err && r_cap) ? r_cap_idx : 4'd0;
        end
    end

    assign bus.ready              = r_ready;
    assign bus.done               = r_done;
    assign bus.error              = r_error;
    assign bus.captured           = r_captured;
    assign bus.captured_piece     = r_captured_piece;
    assign bus.location_vectors_w = r_loc_w;
    assign bus.location_vectors_b = r_loc_b;
    assign bus.alive_vectors_w    = r_alive_w;
    assign bus.alive_vectors_b    = r_alive_b;

endmodule

// File: tb/tb_move_executor.sv
// Bench for move_executor: directed move table from the opening, a reset
// abort during a scan, and random moves checked against a board model.
module tb_move_executor;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    move_executor_if bus ();

    move_executor #(.WHITE(1'b1), .BLACK(1'b0)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Board model: side 1 = white (pl=1), side 0 = black.
    int m_sq[2][16];
    bit m_al[2][16];

    typedef struct {
        bit pl;
        int piece;
        int sq;
        bit err;
        bit cap;
        int cp;
        int lat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void m_reset();
        int back[8] = '{4, 3, 5, 2, 6, 1, 7, 0};
        for (int i = 0; i < 16; i++) begin
            m_sq[1][i] = (i < 8) ? back[i] : 23 - i;
            m_sq[0][i] = (i < 8) ? 56 + back[i] : 63 - i;
            m_al[1][i] = 1'b1;
            m_al[0][i] = 1'b1;
        end
    endfunction

    function automatic logic [95:0] m_loc(input int s);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[6*i +: 6] = 6'(m_sq[s][i]);
        return r;
    endfunction

    function automatic logic [15:0] m_alv(input int s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = m_al[s][i];
        return r;
    endfunction

    // Outcome from the rules: dead mover rejected after CHECK, any live own
    // piece on the target rejected at its scan index, else legal (19 cycles).
    function automatic void m_predict(input bit p, input int pc, input int sq,
                                      output bit e, output bit c, output int cp, output int lat);
        int me;
        int op;
        me = p ? 1 : 0;
        op = 1 - me;
        e = 1'b0; c = 1'b0; cp = 0; lat = 19;
        if (!m_al[me][pc]) begin
            e = 1'b1; lat = 2;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (m_al[me][k] && m_sq[me][k] == sq) begin
                e = 1'b1; lat = 3 + k;
                return;
            end
        end
        for (int k = 0; k < 16; k++) begin
            if (m_al[op][k] && m_sq[op][k] == sq) begin
                c = 1'b1; cp = k;
            end
        end
    endfunction

    function automatic void m_commit(input bit p, input int pc, input int sq,
                                     input bit e, input bit c, input int cp);
        int me;
        me = p ? 1 : 0;
        if (!e) begin
            m_sq[me][pc] = sq;
            if (c) m_al[1 - me][cp] = 1'b0;
        end
    endfunction

    task automatic chk_board(input string nm);
        chk({nm, "_locw"}, bus.location_vectors_w, m_loc(1));
        chk({nm, "_locb"}, bus.location_vectors_b, m_loc(0));
        chk({nm, "_alvw"}, {80'd0, bus.alive_vectors_w}, {80'd0, m_alv(1)});
        chk({nm, "_alvb"}, {80'd0, bus.alive_vectors_b}, {80'd0, m_alv(0)});
    endtask

    // Called at a negedge. Holds move_valid through the busy period so any
    // re-acceptance would show up; returns the done cycle (0 on timeout).
    task automatic do_move(input bit p, input int pc, input int sq,
                           output int lat, output bit e, output bit c, output int cp);
        chk("ready_idle", {95'd0, bus.ready}, 96'd1);
        bus.pl         = p;
        bus.piece_in   = 4'(pc);
        bus.move_in    = 6'(sq);
        bus.move_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0; e = 1'b0; c = 1'b0; cp = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.done) begin
                lat = n;
                e   = bus.error;
                c   = bus.captured;
                cp  = int'(bus.captured_piece);
                break;
            end
            if (bus.ready !== 1'b0) begin
                n_vec++; n_bad++;
                $display("FAIL busy_ready: got ready=%b expected 0 at cycle %0d", bus.ready, n);
            end
            @(posedge clk); #1;
        end
        bus.move_valid = 1'b0;
        if (lat == 0) begin
            n_vec++; n_bad++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        @(posedge clk); #1;
        chk("done_one_cycle", {95'd0, bus.done}, 96'd0);
        chk("ready_after", {95'd0, bus.ready}, 96'd1);
        @(negedge clk);
    endtask

    task automatic model_move(input string nm, input bit p, input int pc, input int sq);
        bit e, c, ee, ec;
        int cp, lat, ecp, elat;
        m_predict(p, pc, sq, ee, ec, ecp, elat);
        do_move(p, pc, sq, lat, e, c, cp);
        chk({nm, "_lat"}, 96'(lat), 96'(elat));
        chk({nm, "_err"}, {95'd0, e}, {95'd0, ee});
        chk({nm, "_cap"}, {95'd0, c}, {95'd0, ec});
        chk({nm, "_cpc"}, 96'(cp), 96'(ecp));
        m_commit(p, pc, sq, ee, ec, ecp);
        chk_board(nm);
    endtask

    initial begin
        bit e, c;
        int cp, lat, dn, p, pc, sq;
        logic [95:0] v;

        bus.move_valid = 1'b0;
        bus.pl         = 1'b0;
        bus.piece_in   = 4'd0;
        bus.move_in    = 6'd0;
        m_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
        chk("rst_ready", {95'd0, bus.ready}, 96'd1);
        chk("rst_done", {95'd0, bus.done}, 96'd0);
        chk("rst_error", {95'd0, bus.error}, 96'd0);
        chk("rst_captured", {95'd0, bus.captured}, 96'd0);
        chk("rst_cpiece", {92'd0, bus.captured_piece}, 96'd0);
        chk("rst_alive_w", {80'd0, bus.alive_vectors_w}, {80'd0, 16'hFFFF});
        chk("rst_alive_b", {80'd0, bus.alive_vectors_b}, {80'd0, 16'hFFFF});
        v = bus.location_vectors_w;
        chk("rst_wK1", {90'd0, v[5:0]}, 96'd4);
        chk("rst_wP1", {90'd0, v[95:90]}, 96'd8);
        v = bus.location_vectors_b;
        chk("rst_bK1", {90'd0, v[5:0]}, 96'd60);
        chk("rst_bR1", {90'd0, v[47:42]}, 96'd56);
        chk_board("rst");

        // Directed table from the opening position.
        tbl[0] = '{pl: 1'b1, piece: 15, sq: 24, err: 1'b0, cap: 1'b0, cp: 0,  lat: 19};
        tbl[1] = '{pl: 1'b1, piece: 0,  sq: 3,  err: 1'b1, cap: 1'b0, cp: 0,  lat: 4};
        tbl[2] = '{pl: 1'b0, piece: 15, sq: 16, err: 1'b0, cap: 1'b0, cp: 0,  lat: 19};
        tbl[3] = '{pl: 1'b1, piece: 7,  sq: 16, err: 1'b0, cap: 1'b1, cp: 15, lat: 19};
        tbl[4] = '{pl: 1'b0, piece: 15, sq: 40, err: 1'b1, cap: 1'b0, cp: 0,  lat: 2};
        tbl[5] = '{pl: 1'b1, piece: 1,  sq: 3,  err: 1'b1, cap: 1'b0, cp: 0,  lat: 4};
        for (int i = 0; i < 6; i++) begin
            do_move(tbl[i].pl, tbl[i].piece, tbl[i].sq, lat, e, c, cp);
            chk($sformatf("tbl%0d_lat", i), 96'(lat), 96'(tbl[i].lat));
            chk($sformatf("tbl%0d_err", i), {95'd0, e}, {95'd0, tbl[i].err});
            chk($sformatf("tbl%0d_cap", i), {95'd0, c}, {95'd0, tbl[i].cap});
            chk($sformatf("tbl%0d_cpc", i), 96'(cp), 96'(tbl[i].cp));
            m_commit(tbl[i].pl, tbl[i].piece, tbl[i].sq, tbl[i].err, tbl[i].cap, tbl[i].cp);
            chk_board($sformatf("tbl%0d", i));
        end
        chk("seq_alive_b", {80'd0, bus.alive_vectors_b}, {80'd0, 16'h7FFF});
        v = bus.location_vectors_w;
        chk("seq_wR1", {90'd0, v[47:42]}, 96'd16);
        chk("seq_wP1", {90'd0, v[95:90]}, 96'd24);

        // Random moves against the model; half aim at occupied squares.
        for (int i = 0; i < 60; i++) begin
            p  = int'($urandom_range(0, 1));
            pc = int'($urandom_range(0, 15));
            if ($urandom_range(0, 4) != 0) begin
                for (int t = 0; t < 16 && !m_al[p][pc]; t++) pc = int'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) != 0)
                sq = m_sq[$urandom_range(0, 1)][$urandom_range(0, 15)];
            else
                sq = int'($urandom_range(0, 63));
            model_move($sformatf("rnd%0d", i), p[0], pc, sq);
        end

        // Reset during SCAN: no done, opening board restored in that cycle.
        bus.pl = 1'b1; bus.piece_in = 4'd0; bus.move_in = 6'd35; bus.move_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.move_valid = 1'b0;
        repeat (5) @(negedge clk);
        RST = 1'b1;
        @(posedge clk); #1;
        m_reset();
        chk("abort_ready", {95'd0, bus.ready}, 96'd1);
        chk("abort_done", {95'd0, bus.done}, 96'd0);
        chk_board("abort");
        @(negedge clk);
        RST = 1'b0;
        dn = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        chk("abort_no_done", 96'(dn), 96'd0);
        @(negedge clk);

        // A few moves after the abort to confirm clean recovery.
        model_move("post0", 1'b1, 12, 27);
        model_move("post1", 1'b0, 11, 35);
        model_move("post2", 1'b1, 12, 35);
        model_move("post3", 1'b1, 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 The block SHALL use reset RST, synchronous, active-high, and clock clk.
REQ-002 Parameter WHITE, default 1'b1, meaning: pl value selecting the white side.
REQ-003 Parameter BLACK, default 1'b0, meaning: pl value selecting the black side.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 move_valid  input  1  move request; qualified by ready.
REQ-007 pl  input  1  side to move (WHITE/BLACK).
REQ-008 piece_in  input  4  piece index: K1=0, Q1=1, B2=2, B1=3, N2=4, N1=5, R2=6, R1=7, P8..P1=8..15.
REQ-009 move_in  input  6  destination square, rank*8+file (a1=0, h8=63).
REQ-010 ready  output  1  high in IDLE only.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 error  output  1  move rejected; valid while done=1.
REQ-013 captured  output  1  opponent piece removed; valid while done=1.
REQ-014 captured_piece  output  4  index of removed piece; valid while captured=1.
REQ-015 location_vectors_w / location_vectors_b  output  96  piece i square in bits [6i+5:6i].
REQ-016 alive_vectors_w / alive_vectors_b  output  16  bit i set = piece i on board.

Function
REQ-017 FSM states SHALL be IDLE, CHECK, SCAN, COMMIT, DONE; all outputs registered.
REQ-018 IDLE: request accepted on an edge with move_valid=1 and ready=1; pl, piece_in, move_in latched; next state CHECK.
REQ-019 move_valid while ready=0 SHALL be ignored; no queuing.
REQ-020 CHECK: mover alive bit (mover side) clear -> DONE with error=1; else SCAN with index k=0, capture flag cleared.
REQ-021 SCAN: one index k per cycle, k=0..15; mover side piece k alive and at move_in -> immediate DONE with error=1 (includes mover itself, so null move is an error).
REQ-022 SCAN: opponent piece k alive and at move_in -> capture flag set, capture index = k; dead pieces never match.
REQ-023 SCAN at k=15 without error -> COMMIT; k is a 4-bit counter, no wrap beyond 15.
REQ-024 COMMIT: mover location field := move_in; if capture flag, opponent alive bit cleared (location field unchanged); next DONE.
REQ-025 DONE: done=1 for exactly one cycle with error/captured/captured_piece; next IDLE.
REQ-026 Latency, legal move: done high in the 19th cycle after the accepting edge (CHECK 1, SCAN 16, COMMIT 1, DONE 1).
REQ-027 Latency, dead-mover error: done high in the 2nd cycle after acceptance; own-square error at index k: done high in cycle 3+k.
REQ-028 Board state SHALL change only in COMMIT; rejected moves leave all vectors unchanged.
REQ-029 error and captured SHALL never both be 1; captured_piece = 0 when captured=0.
REQ-030 No legality check beyond occupancy and liveness (piece movement rules excluded).

Reset
REQ-031 RST SHALL force IDLE, ready=1, done=0, error=0, captured=0, captured_piece=0, alive_vectors_w/b=16'hFFFF.
REQ-032 Reset white squares: K1=4, Q1=3, B1=2, B2=5, N1=1, N2=6, R1=0, R2=7, P1..P8=8..15 (P1=8).
REQ-033 Reset black squares: same files +56 (K1=60, Q1=59, R1=56, R2=63, P1..P8=48..55).
REQ-034 RST mid-operation SHALL abort with no done pulse and restore the initial board in that cycle.

Verification
REQ-035 After reset, pl=1, piece_in=15, move_in=24 -> done at cycle 19, error=0, captured=0, location_vectors_w[95:90]=24.
REQ-036 pl=1, piece_in=0 (K1), move_in=3 (own Q1, index 1) -> done at cycle 4, error=1, board unchanged.
REQ-037 Black P1 moved to 16, then white R1 (0) to 16 -> captured=1, captured_piece=15, alive_vectors_b=16'h7FFF, white R1 field=16.
REQ-038 Move previously captured black P1 -> done at cycle 2, error=1; move_valid held during busy -> exactly one done per accept.
REQ-039 RST asserted during SCAN -> no done, ready=1 next cycle, all vectors equal REQ-031..033 values.
REQ-040 Null move (piece_in=1 to its own square 3) -> error=1, done at cycle 4.
